// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program into instruction memory with the core held
// in reset, releases it, and detects the final fetch to stop the run.
module cpu_run_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    input  logic [31:0]       pc,
    input  logic [31:0]       ins,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    logic [2:0]           state;
    logic [ADDR_W-1:0]    last_idx;
    logic [31:0]          last_word;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_nxt;
    logic [3:0]           drain_cnt;
    logic [ADDR_W-1:0]    waddr;
    logic                 accept;
    logic                 halt_hit;

    assign waddr    = word_count[ADDR_W-1:0];
    assign accept   = (state == S_LOAD) && ld_valid;
    assign wdog_nxt = wdog + 1'b1;

    // Full 32-bit compare: any PC bit above the program window blocks a match.
    assign halt_hit = (pc == {{(30-ADDR_W){1'b0}}, last_idx, 2'b00})
                   && (ins == last_word);

    assign ld_ready = (state == S_LOAD);
    assign cpu_rst  = !((state == S_RUN) || (state == S_DRAIN));
    assign busy     = (state == S_LOAD) || (state == S_RELEASE)
                   || (state == S_RUN)  || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            last_idx   <= '0;
            last_word  <= '0;
            wdog       <= '0;
            drain_cnt  <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_waddr <= waddr;
                imem_wdata <= ld_data;
                last_idx   <= waddr;
                last_word  <= ld_data;
                word_count <= word_count + 1'b1;
            end
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LOAD;
                        word_count <= '0;
                        wdog       <= '0;
                        drain_cnt  <= '0;
                        last_idx   <= '0;
                        last_word  <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (ld_last)
                            state <= S_RELEASE;
                        else if (&waddr)
                            state <= S_ERR;
                    end
                end
                S_RELEASE: state <= S_RUN;
                S_RUN: begin
                    wdog <= wdog_nxt;
                    if (halt_hit) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 4'(DRAIN_CYCLES - 1);
                    end else if (&wdog_nxt) begin
                        state <= S_ERR;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 4'd0)
                        state <= S_DONE;
                    else
                        drain_cnt <= drain_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected writes and end-of-run events
// are queued by the stimulus and consumed by an independent monitor.
module tb_cpu_run_ctrl;

    localparam int AW = 3;
    localparam int DC = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic [31:0]   pc;
    logic [31:0]   ins;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    cpu_run_ctrl #(
        .ADDR_W(AW),
        .DRAIN_CYCLES(DC),
        .TIMEOUT_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .pc(pc),
        .ins(ins),
        .busy(busy),
        .done(done),
        .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    typedef struct {
        bit is_err;
        int at;
    } tm_t;

    wr_t wq[$];
    tm_t tq[$];

    logic [31:0] prog [8];
    int          mode = 0;
    logic [31:0] core_pc;

    // Model core: straight-line fetch from the bench's own program image.
    // mode 1 corrupts fetched words, mode 2 sets a PC bit above the window.
    always @(posedge clk or posedge rst) begin
        if (rst || cpu_rst) core_pc <= '0;
        else core_pc <= core_pc + 32'd4;
    end

    always_comb begin
        pc  = (mode == 2) ? (core_pc | 32'h20) : core_pc;
        ins = prog[core_pc[4:2]] ^ ((mode == 1) ? 32'd1 : 32'd0);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    logic pd = 1'b0;
    logic pe = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected no write",
                             imem_waddr, imem_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("waddr", imem_waddr, w.a);
                    chk("wdata", imem_wdata, w.d);
                end
            end
            if ((done && !pd) || (err && !pe)) begin
                if (tq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL term_unexpected: got done=%0b err=%0b expected none",
                             done, err);
                end else begin
                    tm_t t;
                    t = tq.pop_front();
                    chk("term_kind", err, t.is_err);
                    chk("term_cycle", cyc, t.at);
                    chk("term_cpu_rst", cpu_rst, 1);
                end
            end
            pd = done;
            pe = err;
        end else begin
            pd = 1'b0;
            pe = 1'b0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gaps: 0 none, 1 alternate valid, 2 random valid
    task automatic run_prog(input int n, input bit with_last, input int gaps,
                            input int m, input bit rst_mid);
        int i;
        int r;
        bit ovf;
        bit tog;
        bit g;
        i = 0;
        tog = 1'b0;
        mode = m;
        ovf = !with_last;
        pulse_start();
        chk("wc_clear", word_count, 0);
        chk("flags_clear", {done, err}, 0);
        chk("ready_load", ld_ready, 1);
        while (i < n) begin
            g = (gaps == 1) ? tog : ((gaps == 2) && ($urandom_range(1, 0) == 1));
            tog = !tog;
            if (g) begin
                ld_valid = 1'b0;
                ld_last  = ($urandom_range(1, 0) == 1);
                @(negedge clk);
                chk("ready_gap", ld_ready, 1);
            end else begin
                chk("ready_pre", ld_ready, 1);
                ld_valid = 1'b1;
                ld_data  = prog[i];
                ld_last  = with_last && (i == n - 1);
                wq.push_back('{AW'(i), prog[i]});
                if (ovf && i == n - 1) tq.push_back('{1'b1, cyc + 1});
                @(negedge clk);
                i++;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("wc_final", word_count, n);
        chk("ready_drop", ld_ready, 0);
        chk("cpu_rst_hold", cpu_rst, 1);
        if (ovf) begin
            chk("ovf_err", err, 1);
            repeat (3) @(negedge clk);
            chk("ovf_cpu_rst", cpu_rst, 1);
            chk("ovf_wc", word_count, n);
        end else begin
            @(negedge clk);
            chk("cpu_rst_fall", cpu_rst, 0);
            chk("busy_run", busy, 1);
            r = cyc;
            if (m == 0) tq.push_back('{1'b0, r + (n - 1) + 1 + DC});
            else tq.push_back('{1'b1, r + (1 << TW) - 1});
            if (rst_mid) begin
                pulse_start();
                chk("start_in_run_busy", busy, 1);
                chk("start_in_run_cpu_rst", cpu_rst, 0);
                chk("start_in_run_wc", word_count, n);
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst_cpu_rst", cpu_rst, 1);
                chk("rst_busy", busy, 0);
                chk("rst_outs", {ld_ready, imem_we, done, err}, 0);
                chk("rst_wc", word_count, 0);
                tq.delete();
                wq.delete();
                @(negedge clk);
                rst = 1'b0;
            end
        end
        for (int b = 0; b < 200 && (tq.size() != 0 || wq.size() != 0); b++)
            @(negedge clk);
        if (tq.size() != 0 || wq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d events %0d writes pending expected 0",
                     tq.size(), wq.size());
            tq.delete();
            wq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit wl;
        for (int j = 0; j < 8; j++) prog[j] = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_cpu_rst", cpu_rst, 1);
        chk("reset_outs", {ld_ready, imem_we, busy, done, err}, 0);
        chk("reset_addr_data", {imem_waddr, imem_wdata}, 0);
        chk("reset_wc", word_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cpu_rst", cpu_rst, 1);

        prog[0] = 32'h00500093;
        prog[1] = 32'h00100113;
        prog[2] = 32'h002081b3;
        prog[3] = 32'h00000013;
        run_prog(4, 1'b1, 0, 0, 1'b0);
        run_prog(4, 1'b1, 1, 0, 1'b0);
        prog[1] = 32'h00000013;
        run_prog(4, 1'b1, 0, 0, 1'b0);
        for (int j = 0; j < 8; j++) prog[j] = 32'h1000 + 32'(j);
        run_prog(8, 1'b0, 0, 0, 1'b0);
        run_prog(4, 1'b1, 0, 1, 1'b0);
        run_prog(2, 1'b1, 0, 0, 1'b0);
        run_prog(5, 1'b1, 0, 1, 1'b1);

        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < 8; j++) prog[j] = $urandom;
            n  = $urandom_range(8, 1);
            wl = (n < 8) ? 1'b1 : ($urandom_range(1, 0) == 1);
            run_prog(n, wl, 2, $urandom_range(2, 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
